uart_tx_arbiter: RTL and testbench

//  Shares the single UART TX serializer among three sensor report sources: 0=clock, 1=ultrasonic, 2=temp/humidity.

---
 rtl/uart_arb_pkg.sv | 39 +++
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/rr_pick3.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM encoding, source ids
// and small index helpers used by the arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int N_SRC  = 3;
  localparam int DATA_W = 8;

  localparam int SRC_CLK = 0;
  localparam int SRC_US  = 1;
  localparam int SRC_TH  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    WAIT_ACC  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // Successor of a source index, wrapping after the last source.
  function automatic logic [1:0] next_src(input logic [1:0] idx);
    logic [1:0] nxt;
    if (idx >= 2'(SRC_TH)) nxt = 2'(SRC_CLK);
    else                   nxt = idx + 2'd1;
    return nxt;
  endfunction

  function automatic logic [N_SRC-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [N_SRC-1:0] oh;
    oh = '0;
    case (idx)
      2'(SRC_CLK): oh = 3'b001;
      2'(SRC_US):  oh = 3'b010;
      2'(SRC_TH):  oh = 3'b100;
      default:     oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the report sources, the arbiter and the shared uart_tx core.
// master = arbiter side, slave = sources plus serializer side.
interface uart_tx_arbiter_if;
  import uart_arb_pkg::*;

  logic [N_SRC-1:0]        req;
  logic [N_SRC-1:0]        byte_valid;
  logic [N_SRC*DATA_W-1:0] byte_data;
  logic [N_SRC-1:0]        byte_last;
  logic [N_SRC-1:0]        byte_ack;
  logic [N_SRC-1:0]        grant;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    timeout_err;

  modport master (
    input  req, byte_valid, byte_data, byte_last, tx_busy,
    output byte_ack, grant, tx_start, tx_data, timeout_err
  );

  modport slave (
    output req, byte_valid, byte_data, byte_last, tx_busy,
    input  byte_ack, grant, tx_start, tx_data, timeout_err
  );

endinterface

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first asserted request scanning ptr,
// ptr+1, ptr+2 (mod 3). onehot is zero when nothing is requesting.
module rr_pick3
  import uart_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_SRC-1:0] onehot,
  output logic [1:0]       idx
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    cand   = (ptr > 2'(SRC_TH)) ? 2'(SRC_CLK) : ptr;
    idx    = cand;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = next_src(cand);
    end
    if (found) onehot = idx_to_onehot(idx);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among three report sources, one whole
// message per grant. Optional byte-gap watchdog under `ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
)(
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [N_SRC-1:0]  byte_ack_q, byte_ack_d;

  logic [N_SRC-1:0]  pick_onehot;
  logic [1:0]        pick_idx;
  logic              owner_req, owner_valid, owner_last;
  logic [DATA_W-1:0] owner_byte;
  logic              wd_fire;

  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);

  rr_pick3 u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign owner_req   = bus.req[owner_q];
  assign owner_valid = bus.byte_valid[owner_q];
  assign owner_last  = bus.byte_last[owner_q];
  assign owner_byte  = bus.byte_data[owner_q*DATA_W +: DATA_W];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    byte_ack_d = '0;
    case (state_q)
      IDLE: begin
        // A residual frame on the line holds off any new owner.
        if (!bus.tx_busy && (|bus.req)) begin
          grant_d = pick_onehot;
          owner_d = pick_idx;
          state_d = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (!owner_req || wd_fire) begin
          grant_d  = '0;
          rr_ptr_d = next_src(owner_q);
          state_d  = IDLE;
        end else if (owner_valid) begin
          tx_data_d  = owner_byte;
          tx_start_d = 1'b1;
          byte_ack_d = idx_to_onehot(owner_q);
          last_d     = owner_last;
          state_d    = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        // A withdrawn request ends the message after the byte in flight.
        if (!owner_req) last_d = 1'b1;
        if (bus.tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q || !owner_req) begin
            grant_d  = '0;
            rr_ptr_d = next_src(owner_q);
            state_d  = IDLE;
          end else begin
            state_d = WAIT_BYTE;
          end
        end else if (!owner_req) begin
          last_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      byte_ack_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      byte_ack_q <= byte_ack_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.byte_ack = byte_ack_q;

`ifdef ARB_TIMEOUT_EN
  logic [19:0] wd_cnt_q;
  logic        timeout_err_q;

  // Owner still requesting but silent for the whole gap budget.
  assign wd_fire = (state_q == WAIT_BYTE) && owner_req && !owner_valid &&
                   (wd_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_d == WAIT_BYTE && state_q != WAIT_BYTE) wd_cnt_q <= '0;
      else if (state_q == WAIT_BYTE)                    wd_cnt_q <= wd_cnt_q + 20'd1;
      if (wd_fire) timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg   = ^TO_LAST;
  assign wd_fire         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table with a hand-driven tx_busy,
// then queue-fed sources and a uart_tx model for multi-message sequences.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int BUSY_CYC = 40;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.TIMEOUT_CYC(100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic        bfm_on;
  logic [2:0]  t_req, t_bv, t_bl;
  logic [23:0] t_bd;
  logic        t_busy;
  logic [2:0]  b_req, b_bv, b_bl;
  logic [23:0] b_bd;
  logic        mbusy;
  int          mcnt;
  logic [2:0]  hold;

  logic [8:0]  q0[$], q1[$], q2[$];
  logic [10:0] logq[$];
  int          proto_err;
  int          ack0_cnt;

  int checks = 0;
  int errors = 0;

  assign bus.req        = bfm_on ? b_req : t_req;
  assign bus.byte_valid = bfm_on ? b_bv  : t_bv;
  assign bus.byte_last  = bfm_on ? b_bl  : t_bl;
  assign bus.byte_data  = bfm_on ? b_bd  : t_bd;
  assign bus.tx_busy    = bfm_on ? mbusy : t_busy;

  // uart_tx model: busy from the cycle after tx_start for 10 bit-times.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (bus.tx_start) begin
      mbusy <= 1'b1;
      mcnt  <= BUSY_CYC - 1;
    end else if (mbusy) begin
      if (mcnt == 0) mbusy <= 1'b0;
      else           mcnt  <= mcnt - 1;
    end
  end

  initial begin
    proto_err = 0;
    ack0_cnt  = 0;
  end

  // Sources pop on their ack and present the next queued byte; monitor logs issues.
  always @(negedge clk) begin
    if (bfm_on && reset_n) begin
      if (bus.tx_start) begin
        logq.push_back({bus.grant, bus.tx_data});
        if (mbusy) proto_err++;
      end
      if ((bus.byte_ack & ~bus.grant) != 3'b000) proto_err++;
      if ((bus.grant & (bus.grant - 3'd1)) != 3'b000) proto_err++;
      if (bus.byte_ack[0]) ack0_cnt++;
      if (bus.byte_ack[0] && q0.size() > 0) void'(q0.pop_front());
      if (bus.byte_ack[1] && q1.size() > 0) void'(q1.pop_front());
      if (bus.byte_ack[2] && q2.size() > 0) void'(q2.pop_front());
    end
    b_req[0] = (q0.size() > 0) || hold[0];
    b_req[1] = (q1.size() > 0) || hold[1];
    b_req[2] = (q2.size() > 0) || hold[2];
    b_bv     = {q2.size() > 0, q1.size() > 0, q0.size() > 0};
    b_bd[7:0]   = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    b_bd[15:8]  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    b_bd[23:16] = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
    b_bl[0]  = (q0.size() > 0) ? q0[0][8] : 1'b0;
    b_bl[1]  = (q1.size() > 0) ? q1[0][8] : 1'b0;
    b_bl[2]  = (q2.size() > 0) ? q2[0][8] : 1'b0;
  end

  typedef struct packed {
    logic [2:0]  req;
    logic [2:0]  bv;
    logic [2:0]  bl;
    logic [23:0] bd;
    logic        busy;
    logic [2:0]  e_grant;
    logic        e_start;
    logic [2:0]  e_ack;
    logic [7:0]  e_data;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] bv,
                              input logic [2:0] bl, input logic [23:0] bd,
                              input logic busy, input logic [2:0] g,
                              input logic s, input logic [2:0] a, input logic [7:0] d);
    vec_t v;
    v.req = req; v.bv = bv; v.bl = bl; v.bd = bd; v.busy = busy;
    v.e_grant = g; v.e_start = s; v.e_ack = a; v.e_data = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] lg(input int k);
    if (k < logq.size()) return logq[k];
    return 11'h7ff;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && hold == 3'b000 &&
             bus.grant == 3'b000 && !mbusy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " idle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t tv[24];
  int   lb;

  initial begin
    #500us;
    $display("FAIL global time limit: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_n = 1'b0;
    bfm_on  = 1'b0;
    hold    = 3'b000;
    t_req = '0; t_bv = '0; t_bl = '0; t_bd = '0; t_busy = 1'b0;

    tv[0]  = mk(3'b000, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00);
    tv[1]  = mk(3'b010, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 3'b000, 8'h00);
    tv[2]  = mk(3'b010, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b010, 1'b0, 3'b000, 8'h00);
    tv[3]  = mk(3'b010, 3'b010, 3'b010, 24'h00a500, 1'b0, 3'b010, 1'b1, 3'b010, 8'ha5);
    tv[4]  = mk(3'b010, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b010, 1'b0, 3'b000, 8'ha5);
    tv[5]  = mk(3'b010, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b010, 1'b0, 3'b000, 8'ha5);
    tv[6]  = mk(3'b010, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b010, 1'b0, 3'b000, 8'ha5);
    tv[7]  = mk(3'b010, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 3'b000, 8'ha5);
    tv[8]  = mk(3'b011, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b001, 1'b0, 3'b000, 8'ha5);
    tv[9]  = mk(3'b011, 3'b001, 3'b000, 24'h000031, 1'b0, 3'b001, 1'b1, 3'b001, 8'h31);
    tv[10] = mk(3'b011, 3'b001, 3'b000, 24'h000032, 1'b0, 3'b001, 1'b0, 3'b000, 8'h31);
    tv[11] = mk(3'b011, 3'b001, 3'b000, 24'h000032, 1'b1, 3'b001, 1'b0, 3'b000, 8'h31);
    tv[12] = mk(3'b011, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b001, 1'b0, 3'b000, 8'h31);
    tv[13] = mk(3'b011, 3'b011, 3'b001, 24'h00ee32, 1'b0, 3'b001, 1'b1, 3'b001, 8'h32);
    tv[14] = mk(3'b011, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b001, 1'b0, 3'b000, 8'h32);
    tv[15] = mk(3'b011, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 3'b000, 8'h32);
    tv[16] = mk(3'b011, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b010, 1'b0, 3'b000, 8'h32);
    tv[17] = mk(3'b001, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 3'b000, 8'h32);
    tv[18] = mk(3'b001, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b001, 1'b0, 3'b000, 8'h32);
    tv[19] = mk(3'b001, 3'b001, 3'b000, 24'h000077, 1'b0, 3'b001, 1'b1, 3'b001, 8'h77);
    tv[20] = mk(3'b000, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b001, 1'b0, 3'b000, 8'h77);
    tv[21] = mk(3'b000, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b001, 1'b0, 3'b000, 8'h77);
    tv[22] = mk(3'b000, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 3'b000, 8'h77);
    tv[23] = mk(3'b000, 3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 3'b000, 8'h77);

    repeat (3) @(negedge clk);
    chk("reset grant",       32'(bus.grant),       32'd0);
    chk("reset tx_start",    32'(bus.tx_start),    32'd0);
    chk("reset byte_ack",    32'(bus.byte_ack),    32'd0);
    chk("reset tx_data",     32'(bus.tx_data),     32'd0);
    chk("reset timeout_err", 32'(bus.timeout_err), 32'd0);
    reset_n = 1'b1;

    // Cycle table: hold-off on busy, single-byte message, ignored non-owner
    // bytes, owner drop in WAIT_BYTE and in WAIT_ACC.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      t_req = tv[i].req; t_bv = tv[i].bv; t_bl = tv[i].bl;
      t_bd  = tv[i].bd;  t_busy = tv[i].busy;
      @(posedge clk); #1;
      chk($sformatf("v%0d grant", i),    32'(bus.grant),    32'(tv[i].e_grant));
      chk($sformatf("v%0d tx_start", i), 32'(bus.tx_start), 32'(tv[i].e_start));
      chk($sformatf("v%0d byte_ack", i), 32'(bus.byte_ack), 32'(tv[i].e_ack));
      chk($sformatf("v%0d tx_data", i),  32'(bus.tx_data),  32'(tv[i].e_data));
    end

    @(negedge clk);
    bfm_on = 1'b1;

    // Three-byte message "25C" from source 0.
    @(posedge clk); #2;
    lb = logq.size();
    ack0_cnt = 0;
    q0.push_back({1'b0, 8'h32}); q0.push_back({1'b0, 8'h35}); q0.push_back({1'b1, 8'h43});
    wait_idle("t1", 2000);
    chk("t1 starts", 32'(logq.size() - lb), 32'd3);
    chk("t1 byte0",  32'(lg(lb)),     32'({3'b001, 8'h32}));
    chk("t1 byte1",  32'(lg(lb + 1)), 32'({3'b001, 8'h35}));
    chk("t1 byte2",  32'(lg(lb + 2)), 32'({3'b001, 8'h43}));
    chk("t1 acks",   32'(ack0_cnt),   32'd3);
    chk("t1 grant",  32'(bus.grant),  32'd0);

    // All three request together after reset.
    pulse_reset();
    @(posedge clk); #2;
    lb = logq.size();
    q0.push_back({1'b1, 8'h41}); q1.push_back({1'b1, 8'h42}); q2.push_back({1'b1, 8'h43});
    wait_idle("t2", 4000);
    chk("t2 starts", 32'(logq.size() - lb), 32'd3);
    chk("t2 first",  32'(lg(lb)),     32'({3'b001, 8'h41}));
    chk("t2 second", 32'(lg(lb + 1)), 32'({3'b010, 8'h42}));
    chk("t2 third",  32'(lg(lb + 2)), 32'({3'b100, 8'h43}));

    // Source 0 requests again straight away while source 2 waits.
    @(posedge clk); #2;
    lb = logq.size();
    q0.push_back({1'b1, 8'h78}); q0.push_back({1'b1, 8'h79}); q2.push_back({1'b1, 8'h7a});
    wait_idle("t3", 4000);
    chk("t3 first",  32'(lg(lb)),     32'({3'b001, 8'h78}));
    chk("t3 second", 32'(lg(lb + 1)), 32'({3'b100, 8'h7a}));
    chk("t3 third",  32'(lg(lb + 2)), 32'({3'b001, 8'h79}));

    // Source 1 goes quiet in WAIT_BYTE and then withdraws.
    @(posedge clk); #2;
    lb = logq.size();
    hold[1] = 1'b1;
    q1.push_back({1'b0, 8'h61}); q2.push_back({1'b1, 8'h62});
    begin
      int n = 0;
      while (!(logq.size() > lb && !mbusy) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("t4 first byte wait", 32'(n < 3000), 32'd1);
    end
    repeat (3) @(negedge clk);
    chk("t4 grant held", 32'(bus.grant), 32'b010);
    @(posedge clk); #2;
    hold[1] = 1'b0;
    @(posedge clk); #1;
    chk("t4 released", 32'(bus.grant), 32'd0);
    wait_idle("t4", 3000);
    chk("t4 starts", 32'(logq.size() - lb), 32'd2);
    chk("t4 src1",   32'(lg(lb)),     32'({3'b010, 8'h61}));
    chk("t4 src2",   32'(lg(lb + 1)), 32'({3'b100, 8'h62}));

    // Reset in WAIT_DONE, then a fresh request from source 1.
    @(posedge clk); #2;
    q0.push_back({1'b1, 8'h71});
    begin
      int n = 0;
      while (!mbusy && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t5 busy wait", 32'(n < 100), 32'd1);
    end
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5 grant",    32'(bus.grant),    32'd0);
    chk("t5 tx_start", 32'(bus.tx_start), 32'd0);
    chk("t5 tx_data",  32'(bus.tx_data),  32'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
    lb = logq.size();
    q1.push_back({1'b1, 8'h72});
    wait_idle("t5", 2000);
    chk("t5 starts", 32'(logq.size() - lb), 32'd1);
    chk("t5 src1",   32'(lg(lb)), 32'({3'b010, 8'h72}));

`ifdef ARB_TIMEOUT_EN
    // Owner 0 holds its request without bytes; watchdog hands over to source 1.
    pulse_reset();
    @(posedge clk); #2;
    lb = logq.size();
    hold[0] = 1'b1;
    q1.push_back({1'b1, 8'h6b});
    begin
      int n = 0;
      while (!bus.timeout_err && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("t6 timeout seen", 32'(bus.timeout_err), 32'd1);
      chk("t6 timeout late", 32'(n >= 95), 32'd1);
    end
    hold[0] = 1'b0;
    wait_idle("t6", 2000);
    chk("t6 src1", 32'(lg(lb)), 32'({3'b010, 8'h6b}));
    chk("t6 sticky", 32'(bus.timeout_err), 32'd1);
`else
    chk("timeout_err tied", 32'(bus.timeout_err), 32'd0);
`endif

    chk("protocol/overlap", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
